// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit: holds fetch-time branch predictions and redirects fetch
// when execute resolves one as mispredicted. Optional stats: BRU_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_valid,
   input  logic                       push_taken,
   input  logic [ADDR_W-1:0]          push_target,
   input  logic [ADDR_W-1:0]          push_fallthru,
   input  logic                       res_valid,
   input  logic                       res_taken,
   output logic                       correct_en,
   output logic [ADDR_W-1:0]          correction,
   output logic                       flush,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err_sticky,
   output logic [15:0]                mispred_cnt,
   output logic [15:0]                resolve_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic              taken_q    [DEPTH];
   logic              taken_d    [DEPTH];
   logic [ADDR_W-1:0] target_q   [DEPTH];
   logic [ADDR_W-1:0] target_d   [DEPTH];
   logic [ADDR_W-1:0] fallthru_q [DEPTH];
   logic [ADDR_W-1:0] fallthru_d [DEPTH];

   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              correct_en_q, correct_en_d;
   logic              flush_q, flush_d;
   logic [ADDR_W-1:0] correction_q, correction_d;
   logic              err_sticky_q, err_sticky_d;

   logic              full_w, empty_w, pop_w, mispred_w, push_ok_w;

   assign full_w    = (count_q == CW'(DEPTH));
   assign empty_w   = (count_q == '0);
   assign pop_w     = res_valid && !empty_w;
   assign mispred_w = pop_w && (res_taken != taken_q[rd_ptr_q]);
   // A freed slot from this cycle's pop lets a push in even when full.
   assign push_ok_w = push_valid && (!full_w || pop_w) && !mispred_w;

   always_comb begin
      taken_d      = taken_q;
      target_d     = target_q;
      fallthru_d   = fallthru_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      correct_en_d = mispred_w;
      flush_d      = mispred_w;
      correction_d = correction_q;
      err_sticky_d = err_sticky_q;

      if ((push_valid && full_w && !pop_w) || (res_valid && empty_w)) begin
         err_sticky_d = 1'b1;
      end

      if (mispred_w) begin
         // Everything younger than the head is wrong-path; drop it all.
         correction_d = res_taken ? target_q[rd_ptr_q] : fallthru_q[rd_ptr_q];
         rd_ptr_d     = rd_ptr_q + PW'(1);
         wr_ptr_d     = rd_ptr_q + PW'(1);
         count_d      = '0;
      end else begin
         if (push_ok_w) begin
            taken_d[wr_ptr_q]    = push_taken;
            target_d[wr_ptr_q]   = push_target;
            fallthru_d[wr_ptr_q] = push_fallthru;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_ok_w) - CW'(pop_w);
      end
   end

   always_ff @(posedge clk) begin
      taken_q    <= taken_d;
      target_q   <= target_d;
      fallthru_q <= fallthru_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         correct_en_q <= 1'b0;
         flush_q      <= 1'b0;
         correction_q <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         correct_en_q <= correct_en_d;
         flush_q      <= flush_d;
         correction_q <= correction_d;
         err_sticky_q <= err_sticky_d;
      end
   end

`ifdef BRU_STATS_EN
   logic [15:0] resolve_cnt_q, resolve_cnt_d;
   logic [15:0] mispred_cnt_q, mispred_cnt_d;

   always_comb begin
      resolve_cnt_d = resolve_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (pop_w && (resolve_cnt_q != 16'hFFFF)) begin
         resolve_cnt_d = resolve_cnt_q + 16'd1;
      end
      if (mispred_w && (mispred_cnt_q != 16'hFFFF)) begin
         mispred_cnt_d = mispred_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         resolve_cnt_q <= '0;
         mispred_cnt_q <= '0;
      end else begin
         resolve_cnt_q <= resolve_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign resolve_cnt = resolve_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
`else
   assign resolve_cnt = 16'h0000;
   assign mispred_cnt = 16'h0000;
`endif

   assign correct_en = correct_en_q;
   assign flush      = flush_q;
   assign correction = correction_q;
   assign err_sticky = err_sticky_q;
   assign full       = full_w;
   assign empty      = empty_w;
   assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=4, ADDR_W=10).
`default_nettype none

module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid, push_taken, res_valid, res_taken;
   logic [9:0]  push_target, push_fallthru;
   logic        correct_en, flush, full, empty, err_sticky;
   logic [9:0]  correction;
   logic [2:0]  count;
   logic [15:0] mispred_cnt, resolve_cnt;

   int checks   = 0;
   int failures = 0;
   int n_res    = 0;
   int n_mis    = 0;

   branch_resolve_unit #(.ADDR_W(10), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_taken(push_taken),
      .push_target(push_target), .push_fallthru(push_fallthru),
      .res_valid(res_valid), .res_taken(res_taken),
      .correct_en(correct_en), .correction(correction), .flush(flush),
      .full(full), .empty(empty), .count(count), .err_sticky(err_sticky),
      .mispred_cnt(mispred_cnt), .resolve_cnt(resolve_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_valid = 1'b0; res_valid = 1'b0;
   endtask

   task automatic push(input logic t, input logic [9:0] tgt, input logic [9:0] ft);
      push_valid = 1'b1; push_taken = t; push_target = tgt; push_fallthru = ft;
   endtask

   task automatic resolve(input logic t);
      res_valid = 1'b1; res_taken = t;
   endtask

   function automatic logic [15:0] stat(input int n);
`ifdef BRU_STATS_EN
      return 16'(n);
`else
      return 16'h0000 & 16'(n);
`endif
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two cycles with both request lines active.
      rst = 1'b0;
      push(1'b1, 10'h040, 10'h011);
      resolve(1'b0);
      tick(); tick();
      chk("rst_count", 16'(count), 16'd0);
      chk("rst_empty", 16'(empty), 16'd1);
      chk("rst_full", 16'(full), 16'd0);
      chk("rst_correct_en", 16'(correct_en), 16'd0);
      chk("rst_flush", 16'(flush), 16'd0);
      chk("rst_correction", 16'(correction), 16'd0);
      chk("rst_err", 16'(err_sticky), 16'd0);
      chk("rst_resolve_cnt", resolve_cnt, 16'd0);
      idle();
      rst = 1'b1;
      tick();

      // Correct prediction.
      push(1'b1, 10'h040, 10'h011); tick(); idle();
      chk("cp_count1", 16'(count), 16'd1);
      resolve(1'b1); tick(); idle(); n_res++;
      chk("cp_empty", 16'(empty), 16'd1);
      chk("cp_correct_en", 16'(correct_en), 16'd0);
      chk("cp_resolve_cnt", resolve_cnt, stat(n_res));

      // Mispredict with a younger record flushed.
      push(1'b1, 10'h040, 10'h011); tick();
      push(1'b1, 10'h080, 10'h021); tick(); idle();
      chk("mp_count2", 16'(count), 16'd2);
      resolve(1'b0); tick(); idle(); n_res++; n_mis++;
      chk("mp_correct_en", 16'(correct_en), 16'd1);
      chk("mp_flush", 16'(flush), 16'd1);
      chk("mp_correction", 16'(correction), 16'h011);
      chk("mp_count0", 16'(count), 16'd0);
      chk("mp_mispred_cnt", mispred_cnt, stat(n_mis));
      chk("mp_resolve_cnt", resolve_cnt, stat(n_res));
      tick();
      chk("mp_pulse_end", 16'(correct_en), 16'd0);
      chk("mp_flush_end", 16'(flush), 16'd0);

      // Fill to DEPTH across the pointer wrap.
      push(1'b1, 10'h100, 10'h101); tick();
      push(1'b0, 10'h110, 10'h111); tick();
      push(1'b1, 10'h120, 10'h121); tick();
      push(1'b0, 10'h130, 10'h131); tick();
      chk("fw_full", 16'(full), 16'd1);
      chk("fw_count4", 16'(count), 16'd4);
      push(1'b1, 10'h3FF, 10'h3FE); tick();
      chk("fw_overflow_err", 16'(err_sticky), 16'd1);
      chk("fw_overflow_count", 16'(count), 16'd4);
      // Full: push + correct resolve in the same cycle.
      push(1'b1, 10'h140, 10'h141); resolve(1'b1); tick(); n_res++;
      chk("sim_count4a", 16'(count), 16'd4);
      chk("sim_no_corr_a", 16'(correct_en), 16'd0);
      push(1'b0, 10'h150, 10'h151); resolve(1'b0); tick(); n_res++; idle();
      chk("sim_count4b", 16'(count), 16'd4);
      chk("sim_no_corr_b", 16'(correct_en), 16'd0);
      // Drain in order; any reorder would show as a mispredict pulse.
      resolve(1'b1); tick(); n_res++;
      chk("dr_corr_r2", 16'(correct_en), 16'd0);
      resolve(1'b0); tick(); n_res++;
      chk("dr_corr_r3", 16'(correct_en), 16'd0);
      resolve(1'b1); tick(); n_res++; idle();
      chk("dr_corr_r4", 16'(correct_en), 16'd0);
      chk("dr_count1", 16'(count), 16'd1);
      resolve(1'b1); tick(); n_res++; n_mis++; idle();
      chk("dr_mp_r5", 16'(correct_en), 16'd1);
      chk("dr_mp_r5_addr", 16'(correction), 16'h150);
      chk("dr_resolve_cnt", resolve_cnt, stat(n_res));

      // Full: push + mispredicting resolve in the same cycle.
      push(1'b0, 10'h200, 10'h201); tick();
      push(1'b1, 10'h210, 10'h211); tick();
      push(1'b0, 10'h220, 10'h221); tick();
      push(1'b1, 10'h230, 10'h231); tick();
      chk("fm_full", 16'(full), 16'd1);
      push(1'b1, 10'h240, 10'h241); resolve(1'b1); tick(); n_res++; n_mis++; idle();
      chk("fm_correct_en", 16'(correct_en), 16'd1);
      chk("fm_correction", 16'(correction), 16'h200);
      chk("fm_count0", 16'(count), 16'd0);
      chk("fm_empty", 16'(empty), 16'd1);
      chk("fm_err_unchanged", 16'(err_sticky), 16'd1);
      chk("fm_mispred_cnt", mispred_cnt, stat(n_mis));

      // Reset clears the sticky error; then underflow sets it.
      rst = 1'b0; tick(); rst = 1'b1; n_res = 0; n_mis = 0;
      chk("uf_err_cleared", 16'(err_sticky), 16'd0);
      chk("uf_cnt_cleared", mispred_cnt, 16'd0);
      resolve(1'b1); tick(); idle();
      chk("uf_no_corr", 16'(correct_en), 16'd0);
      chk("uf_err", 16'(err_sticky), 16'd1);
      chk("uf_count", 16'(count), 16'd0);

      // Reset asserted in the same cycle as a mispredicting resolve.
      push(1'b0, 10'h300, 10'h301); tick(); idle();
      chk("rm_count1", 16'(count), 16'd1);
      resolve(1'b1); rst = 1'b0; tick(); idle(); rst = 1'b1;
      chk("rm_correct_en", 16'(correct_en), 16'd0);
      chk("rm_flush", 16'(flush), 16'd0);
      chk("rm_correction", 16'(correction), 16'd0);
      chk("rm_count", 16'(count), 16'd0);
      chk("rm_err", 16'(err_sticky), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
